conv_window_sched: RTL and testbench

Sequencer that drives the 3x3 convolution datapath from the pixel RAM. It walks every valid 3x3 window of an IMG_W x IMG_H image stored row-major in a synchronous-read RAM. For each window it fetches the 9 pixels, presents them to the MAC datapath over a valid/ready handshake and counts returned results. It signals done when all (IMG_W-2)*(IMG_H-2) results are back; it replaces the fixed load-then-convolve counter sequencing with a reusable controller.

---
 rtl/conv_window_sched.sv | 251 +++++++++++++++++++++++++
 tb/tb_conv_window_sched.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_window_sched.sv
// conv_window_sched
// Walks every valid 3x3 window of an IMG_W x IMG_H row-major image held in a
// synchronous-read pixel RAM. For each window the nine pixels are fetched in
// raster order, handed to the MAC datapath over a valid/ready handshake, and
// then the window origin advances. Finished results reported by the MAC are
// counted, and done pulses once all (IMG_W-2)*(IMG_H-2) results are back.
//
// Ports
//   clk        clock, all state on rising edge
//   rst        asynchronous active-high reset
//   start      one-cycle pulse, begins a frame when idle (ignored while busy)
//   busy       high from the cycle after an accepted start until done
//   done       one-cycle pulse when the last result is counted
//   ram_rd     RAM read strobe
//   ram_addr   RAM read address
//   ram_dout   RAM read data, valid one cycle after ram_rd
//   win_valid  window data valid to MAC
//   win_ready  MAC accepts window
//   win_data   tap k = i*3+j (row i, col j) at bits [k*DW +: DW]
//   win_row    top row of current window
//   win_col    left column of current window
//   res_valid  MAC reports one finished result
//   res_cnt    results counted this frame (saturating)
//   ovf        sticky: result seen while idle or beyond the expected count
module conv_window_sched #(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8,
  parameter int DW    = 8,
  parameter int AW    = 6
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  output logic                          busy,
  output logic                          done,
  output logic                          ram_rd,
  output logic [AW-1:0]                 ram_addr,
  input  logic [DW-1:0]                 ram_dout,
  output logic                          win_valid,
  input  logic                          win_ready,
  output logic [9*DW-1:0]               win_data,
  output logic [$clog2(IMG_H)-1:0]      win_row,
  output logic [$clog2(IMG_W)-1:0]      win_col,
  input  logic                          res_valid,
  output logic [$clog2(IMG_W*IMG_H):0]  res_cnt,
  output logic                          ovf
);

  localparam int RW   = $clog2(IMG_H);
  localparam int CW   = $clog2(IMG_W);
  localparam int CNTW = $clog2(IMG_W*IMG_H) + 1;

  localparam logic [CNTW-1:0] N_RES    = CNTW'((IMG_W-2)*(IMG_H-2));
  localparam logic [CNTW-1:0] CNT_MAX  = {CNTW{1'b1}};
  localparam logic [RW-1:0]   LAST_ROW = RW'(IMG_H-3);
  localparam logic [CW-1:0]   LAST_COL = CW'(IMG_W-3);
  // Tap counter value of the final fetch cycle: no read, only the last capture.
  localparam logic [3:0]      TAP_LAST = 4'd9;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FETCH    = 3'd1,
    S_ISSUE    = 3'd2,
    S_ADV      = 3'd3,
    S_WAIT_RES = 3'd4
  } state_t;

  state_t              state_r, state_nxt_s;
  logic [3:0]          tap_r, tap_nxt_s;
  logic [RW-1:0]       row_r, row_nxt_s;
  logic [CW-1:0]       col_r, col_nxt_s;
  logic                busy_r, busy_nxt_s;
  logic                done_r, done_nxt_s;
  logic                rd_r, rd_nxt_s;
  logic [AW-1:0]       addr_r, addr_nxt_s;
  logic                wv_r, wv_nxt_s;
  logic [CNTW-1:0]     cnt_r, cnt_nxt_s;
  logic                ovf_r, ovf_nxt_s;
  logic [9*DW-1:0]     data_r;
  logic [3:0]          cap_idx_s;

  // Pixel address of tap k of the window whose top-left corner is (r, c).
  function automatic logic [AW-1:0] tap_addr(input logic [RW-1:0] r,
                                             input logic [CW-1:0] c,
                                             input logic [3:0]    k);
    int unsigned ti;
    int unsigned tj;
    int unsigned a;
    ti = 32'(k) / 32'd3;
    tj = 32'(k) % 32'd3;
    a  = (32'(r) + ti) * 32'(IMG_W) + 32'(c) + tj;
    return AW'(a);
  endfunction

  // The read for tap k-1 was issued last cycle, so its data lands in slot k-1.
  assign cap_idx_s = tap_r - 4'd1;

  // Next-state, window walk, result accounting and registered-output decode.
  always_comb begin
    state_nxt_s = state_r;
    tap_nxt_s   = tap_r;
    row_nxt_s   = row_r;
    col_nxt_s   = col_r;
    busy_nxt_s  = busy_r;
    done_nxt_s  = 1'b0;
    wv_nxt_s    = 1'b0;
    cnt_nxt_s   = cnt_r;
    ovf_nxt_s   = ovf_r;
    rd_nxt_s    = 1'b0;
    addr_nxt_s  = '0;

    // Results are counted in any busy state; the walk never waits on them.
    if (res_valid) begin
      if (!busy_r || (cnt_r >= N_RES)) begin
        ovf_nxt_s = 1'b1;
      end else begin
        ovf_nxt_s = ovf_r;
      end
      if (busy_r && (cnt_r != CNT_MAX)) begin
        cnt_nxt_s = cnt_r + CNTW'(1);
      end else begin
        cnt_nxt_s = cnt_r;
      end
    end else begin
      ovf_nxt_s = ovf_r;
      cnt_nxt_s = cnt_r;
    end

    case (state_r)
      S_IDLE: begin
        if (start) begin
          state_nxt_s = S_FETCH;
          tap_nxt_s   = 4'd0;
          row_nxt_s   = '0;
          col_nxt_s   = '0;
          busy_nxt_s  = 1'b1;
          cnt_nxt_s   = '0;
          ovf_nxt_s   = 1'b0;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_FETCH: begin
        if (tap_r == TAP_LAST) begin
          state_nxt_s = S_ISSUE;
          tap_nxt_s   = 4'd0;
          wv_nxt_s    = 1'b1;
        end else begin
          tap_nxt_s   = tap_r + 4'd1;
        end
      end
      S_ISSUE: begin
        if (win_ready) begin
          state_nxt_s = S_ADV;
        end else begin
          wv_nxt_s    = 1'b1;
        end
      end
      S_ADV: begin
        if (col_r == LAST_COL) begin
          col_nxt_s = '0;
          row_nxt_s = row_r + RW'(1);
        end else begin
          col_nxt_s = col_r + CW'(1);
        end
        if ((row_r == LAST_ROW) && (col_r == LAST_COL)) begin
          state_nxt_s = S_WAIT_RES;
        end else begin
          state_nxt_s = S_FETCH;
          tap_nxt_s   = 4'd0;
        end
      end
      S_WAIT_RES: begin
        // Uses the post-increment count so a result arriving on entry finishes.
        if (cnt_nxt_s >= N_RES) begin
          state_nxt_s = S_IDLE;
          done_nxt_s  = 1'b1;
          busy_nxt_s  = 1'b0;
        end else begin
          state_nxt_s = S_WAIT_RES;
        end
      end
      default: begin
        state_nxt_s = S_IDLE;
        tap_nxt_s   = 4'd0;
        busy_nxt_s  = 1'b0;
      end
    endcase

    // Read strobe/address are registered, so decode them from the next state.
    if ((state_nxt_s == S_FETCH) && (tap_nxt_s != TAP_LAST)) begin
      rd_nxt_s   = 1'b1;
      addr_nxt_s = tap_addr(row_nxt_s, col_nxt_s, tap_nxt_s);
    end else begin
      rd_nxt_s   = 1'b0;
      addr_nxt_s = '0;
    end
  end

  // State register and registered control outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_IDLE;
      tap_r   <= 4'd0;
      row_r   <= '0;
      col_r   <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      rd_r    <= 1'b0;
      addr_r  <= '0;
      wv_r    <= 1'b0;
      cnt_r   <= '0;
      ovf_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      tap_r   <= tap_nxt_s;
      row_r   <= row_nxt_s;
      col_r   <= col_nxt_s;
      busy_r  <= busy_nxt_s;
      done_r  <= done_nxt_s;
      rd_r    <= rd_nxt_s;
      addr_r  <= addr_nxt_s;
      wv_r    <= wv_nxt_s;
      cnt_r   <= cnt_nxt_s;
      ovf_r   <= ovf_nxt_s;
    end
  end

  // Window tap capture; pixel data is passed through untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_r <= '0;
    end else if ((state_r == S_FETCH) && (tap_r != 4'd0)) begin
      data_r[cap_idx_s*DW +: DW] <= ram_dout;
    end else begin
      data_r <= data_r;
    end
  end

  assign busy      = busy_r;
  assign done      = done_r;
  assign ram_rd    = rd_r;
  assign ram_addr  = addr_r;
  assign win_valid = wv_r;
  assign win_data  = data_r;
  assign win_row   = row_r;
  assign win_col   = col_r;
  assign res_cnt   = cnt_r;
  assign ovf       = ovf_r;

endmodule

// File: tb/tb_conv_window_sched.sv
// Directed bench for conv_window_sched: an 8x8 instance and a 5x4 instance,
// each fed by a RAM model whose pixel value equals its address and a MAC model
// that returns one result two cycles after every window handshake.
module tb_conv_window_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 8x8 instance
  logic rst = 1'b1;
  logic start = 1'b0, win_ready = 1'b1, res_extra = 1'b0;
  logic busy, done, ram_rd, win_valid, res_valid, ovf;
  logic [5:0] ram_addr;
  logic [7:0] ram_dout;
  logic [71:0] win_data;
  logic [2:0] win_row, win_col;
  logic [6:0] res_cnt;

  // 5x4 instance
  logic start2 = 1'b0, win_ready2 = 1'b1;
  logic busy2, done2, ram_rd2, win_valid2, res_valid2, ovf2;
  logic [4:0] ram_addr2;
  logic [7:0] ram_dout2;
  logic [71:0] win_data2;
  logic [1:0] win_row2;
  logic [2:0] win_col2;
  logic [5:0] res_cnt2;

  conv_window_sched #(.IMG_W(8), .IMG_H(8), .DW(8), .AW(6)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .ram_rd(ram_rd), .ram_addr(ram_addr), .ram_dout(ram_dout),
    .win_valid(win_valid), .win_ready(win_ready), .win_data(win_data),
    .win_row(win_row), .win_col(win_col), .res_valid(res_valid),
    .res_cnt(res_cnt), .ovf(ovf)
  );

  conv_window_sched #(.IMG_W(5), .IMG_H(4), .DW(8), .AW(5)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .busy(busy2), .done(done2),
    .ram_rd(ram_rd2), .ram_addr(ram_addr2), .ram_dout(ram_dout2),
    .win_valid(win_valid2), .win_ready(win_ready2), .win_data(win_data2),
    .win_row(win_row2), .win_col(win_col2), .res_valid(res_valid2),
    .res_cnt(res_cnt2), .ovf(ovf2)
  );

  // RAM models: pixel value = address, one-cycle read latency
  always @(posedge clk) begin
    if (ram_rd)  ram_dout  <= {2'b00, ram_addr};
    if (ram_rd2) ram_dout2 <= {3'b000, ram_addr2};
  end

  // MAC models: one result two cycles after each handshake
  logic hs1_d1 = 1'b0, hs1_d2 = 1'b0, hs2_d1 = 1'b0, hs2_d2 = 1'b0;
  always @(posedge clk) begin
    hs1_d1 <= win_valid & win_ready;
    hs1_d2 <= hs1_d1;
    hs2_d1 <= win_valid2 & win_ready2;
    hs2_d2 <= hs2_d1;
  end
  assign res_valid  = hs1_d2 | res_extra;
  assign res_valid2 = hs2_d2;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Handshake / done recorder, sampled mid-cycle
  int hs_n = 0, done_n = 0, hs2_n = 0, done2_n = 0;
  logic [71:0] hs_data [0:255];
  int hs_row [0:255], hs_col [0:255], hs_cyc [0:255];
  logic [71:0] hs2_data [0:15];
  int hs2_row [0:15], hs2_col [0:15];
  always @(negedge clk) begin
    if (win_valid && win_ready) begin
      if (hs_n < 256) begin
        hs_data[hs_n] = win_data;
        hs_row[hs_n]  = int'(win_row);
        hs_col[hs_n]  = int'(win_col);
        hs_cyc[hs_n]  = cyc;
      end
      hs_n++;
    end
    if (done) done_n++;
    if (win_valid2 && win_ready2) begin
      if (hs2_n < 16) begin
        hs2_data[hs2_n] = win_data2;
        hs2_row[hs2_n]  = int'(win_row2);
        hs2_col[hs2_n]  = int'(win_col2);
      end
      hs2_n++;
    end
    if (done2) done2_n++;
  end

  int errors = 0, checks = 0;
  int base, dbase, c0;
  logic [71:0] exp_first, exp_last, exp_stall;
  bit seen;

  task automatic pulse_start();
    @(posedge clk); #1;
    c0 = cyc;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_hs(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      if (hs_n >= target) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++; if ({busy, done, ram_rd, win_valid, ovf} !== 5'b0) begin errors++; $display("FAIL reset_ctrl: got %b expected 00000", {busy, done, ram_rd, win_valid, ovf}); end
    checks++; if (ram_addr !== 6'd0) begin errors++; $display("FAIL reset_addr: got %0d expected 0", ram_addr); end
    checks++; if (win_data !== 72'd0) begin errors++; $display("FAIL reset_data: got %h expected 0", win_data); end
    checks++; if ({win_row, win_col, res_cnt} !== 13'd0) begin errors++; $display("FAIL reset_coord_cnt: got %0d/%0d/%0d expected 0/0/0", win_row, win_col, res_cnt); end
    rst = 1'b0;
    repeat (2) @(posedge clk); #1;
    checks++; if ({busy, ram_rd, busy2} !== 3'b0) begin errors++; $display("FAIL idle_after_reset: got %b expected 000", {busy, ram_rd, busy2}); end
  endtask

  task automatic test_first_window();
    base = hs_n; dbase = done_n;
    pulse_start();
    checks++; if ({busy, ram_rd, ram_addr} !== {1'b1, 1'b1, 6'd0}) begin errors++; $display("FAIL first_read: got busy=%b rd=%b addr=%0d expected 1 1 0", busy, ram_rd, ram_addr); end
    wait_hs(base + 1, 40, seen);
    checks++; if (!seen) begin errors++; $display("FAIL first_hs_timeout: got no handshake expected one"); end
    checks++; if (hs_data[base] !== exp_first) begin errors++; $display("FAIL first_taps: got %h expected %h", hs_data[base], exp_first); end
    checks++; if (hs_row[base] != 0 || hs_col[base] != 0) begin errors++; $display("FAIL first_coord: got (%0d,%0d) expected (0,0)", hs_row[base], hs_col[base]); end
    checks++; if (hs_cyc[base] != c0 + 11) begin errors++; $display("FAIL first_hs_cycle: got %0d expected %0d", hs_cyc[base], c0 + 11); end
  endtask

  task automatic test_full_frame();
    logic [71:0] exp_mid;
    int bad_ord, bad_gap;
    exp_mid = {8'd30, 8'd29, 8'd28, 8'd22, 8'd21, 8'd20, 8'd14, 8'd13, 8'd12};
    wait_done(600, seen);
    checks++; if (!seen) begin errors++; $display("FAIL frame_done_timeout: got no done expected done"); end
    checks++; if ({busy, ovf, res_cnt} !== {1'b0, 1'b0, 7'd36}) begin errors++; $display("FAIL frame_end: got busy=%b ovf=%b cnt=%0d expected 0 0 36", busy, ovf, res_cnt); end
    repeat (5) @(posedge clk); #1;
    checks++; if (done_n - dbase != 1) begin errors++; $display("FAIL done_once: got %0d expected 1", done_n - dbase); end
    checks++; if (hs_n - base != 36) begin errors++; $display("FAIL hs_count: got %0d expected 36", hs_n - base); end
    checks++; if (hs_data[base+10] !== exp_mid) begin errors++; $display("FAIL mid_taps: got %h expected %h", hs_data[base+10], exp_mid); end
    checks++; if (hs_data[base+35] !== exp_last) begin errors++; $display("FAIL last_taps: got %h expected %h", hs_data[base+35], exp_last); end
    checks++; if (hs_row[base+35] != 5 || hs_col[base+35] != 5) begin errors++; $display("FAIL last_coord: got (%0d,%0d) expected (5,5)", hs_row[base+35], hs_col[base+35]); end
    bad_ord = 0; bad_gap = 0;
    for (int n = 0; n < 36; n++) begin
      if (hs_row[base+n] != n / 6 || hs_col[base+n] != n % 6) bad_ord++;
      if (n > 0 && hs_cyc[base+n] - hs_cyc[base+n-1] != 12) bad_gap++;
    end
    checks++; if (bad_ord != 0) begin errors++; $display("FAIL window_order: got %0d bad expected 0", bad_ord); end
    checks++; if (bad_gap != 0) begin errors++; $display("FAIL hs_spacing: got %0d bad gaps expected 0", bad_gap); end
  endtask

  task automatic test_backpressure();
    logic [71:0] snap_d;
    logic [2:0] snap_r, snap_c;
    int bad, rdbad, bad_ord;
    base = hs_n; dbase = done_n;
    pulse_start();
    wait_hs(base + 15, 250, seen);
    win_ready = 1'b0;
    for (int k = 0; k < 30; k++) begin
      if (win_valid === 1'b1) break;
      @(posedge clk); #1;
    end
    checks++; if (win_valid !== 1'b1) begin errors++; $display("FAIL stall_valid: got %b expected 1", win_valid); end
    snap_d = win_data; snap_r = win_row; snap_c = win_col;
    bad = 0; rdbad = 0;
    for (int k = 0; k < 20; k++) begin
      if (win_valid !== 1'b1 || win_data !== snap_d || win_row !== snap_r || win_col !== snap_c) bad++;
      if (ram_rd !== 1'b0) rdbad++;
      @(posedge clk); #1;
    end
    win_ready = 1'b1;
    checks++; if (bad != 0) begin errors++; $display("FAIL stall_stable: got %0d unstable cycles expected 0", bad); end
    checks++; if (rdbad != 0) begin errors++; $display("FAIL stall_no_read: got %0d reads expected 0", rdbad); end
    checks++; if ({snap_r, snap_c} !== {3'd2, 3'd3} || snap_d !== exp_stall) begin errors++; $display("FAIL stall_window: got (%0d,%0d) %h expected (2,3) %h", snap_r, snap_c, snap_d, exp_stall); end
    wait_done(800, seen);
    checks++; if (!seen || res_cnt !== 7'd36) begin errors++; $display("FAIL stall_frame_done: got seen=%b cnt=%0d expected 1 36", seen, res_cnt); end
    bad_ord = 0;
    for (int n = 0; n < 36; n++) if (hs_row[base+n] != n / 6 || hs_col[base+n] != n % 6) bad_ord++;
    checks++; if (hs_n - base != 36 || bad_ord != 0) begin errors++; $display("FAIL stall_frame_windows: got %0d hs %0d bad expected 36 0", hs_n - base, bad_ord); end
  endtask

  task automatic test_reset_mid_fetch();
    int dsave;
    base = hs_n;
    pulse_start();
    wait_hs(base + 7, 200, seen);
    for (int k = 0; k < 10; k++) begin
      if (ram_rd === 1'b1) break;
      @(posedge clk); #1;
    end
    repeat (3) begin @(posedge clk); #1; end
    checks++; if ({ram_rd, ram_addr} !== {1'b1, 6'd17}) begin errors++; $display("FAIL w7_tap3_read: got rd=%b addr=%0d expected 1 17", ram_rd, ram_addr); end
    dsave = done_n;
    #2; rst = 1'b1; #1;
    checks++; if ({busy, done, ram_rd, win_valid, ovf, ram_addr, win_row, win_col, res_cnt} !== 24'd0) begin errors++; $display("FAIL midreset_outputs: got cnt=%0d busy=%b rd=%b expected all 0", res_cnt, busy, ram_rd); end
    checks++; if (win_data !== 72'd0) begin errors++; $display("FAIL midreset_data: got %h expected 0", win_data); end
    repeat (2) @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk); #1;
    checks++; if (done_n != dsave || busy !== 1'b0) begin errors++; $display("FAIL midreset_no_done: got done=%0d busy=%b expected 0 0", done_n - dsave, busy); end
    base = hs_n; dbase = done_n;
    pulse_start();
    wait_done(600, seen);
    checks++; if (!seen || res_cnt !== 7'd36) begin errors++; $display("FAIL refrm_done: got seen=%b cnt=%0d expected 1 36", seen, res_cnt); end
    repeat (3) @(posedge clk); #1;
    checks++; if (hs_n - base != 36 || hs_data[base] !== exp_first || done_n - dbase != 1) begin errors++; $display("FAIL refrm_content: got %0d hs first=%h dones=%0d expected 36 %h 1", hs_n - base, hs_data[base], done_n - dbase, exp_first); end
  endtask

  task automatic test_busy_start_stray();
    int bad_ord;
    base = hs_n;
    pulse_start();
    wait_hs(base + 3, 100, seen);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(600, seen);
    checks++; if (!seen || {ovf, res_cnt} !== {1'b0, 7'd36}) begin errors++; $display("FAIL busystart_done: got seen=%b ovf=%b cnt=%0d expected 1 0 36", seen, ovf, res_cnt); end
    bad_ord = 0;
    for (int n = 0; n < 36; n++) if (hs_row[base+n] != n / 6 || hs_col[base+n] != n % 6) bad_ord++;
    checks++; if (hs_n - base != 36 || bad_ord != 0) begin errors++; $display("FAIL busystart_ignored: got %0d hs %0d bad expected 36 0", hs_n - base, bad_ord); end
    @(posedge clk); #1; res_extra = 1'b1;
    @(posedge clk); #1; res_extra = 1'b0;
    checks++; if ({ovf, res_cnt} !== {1'b1, 7'd36}) begin errors++; $display("FAIL stray_ovf: got ovf=%b cnt=%0d expected 1 36", ovf, res_cnt); end
    pulse_start();
    checks++; if ({ovf, busy, res_cnt} !== {1'b0, 1'b1, 7'd0}) begin errors++; $display("FAIL start_clears: got ovf=%b busy=%b cnt=%0d expected 0 1 0", ovf, busy, res_cnt); end
    wait_done(600, seen);
    checks++; if (!seen) begin errors++; $display("FAIL after_clear_done: got no done expected done"); end
  endtask

  task automatic test_small_image();
    logic [71:0] e0, e5;
    int b2, d2, bad_ord;
    bit ok2;
    e0 = {8'd12, 8'd11, 8'd10, 8'd7, 8'd6, 8'd5, 8'd2, 8'd1, 8'd0};
    e5 = {8'd19, 8'd18, 8'd17, 8'd14, 8'd13, 8'd12, 8'd9, 8'd8, 8'd7};
    b2 = hs2_n; d2 = done2_n;
    @(posedge clk); #1; start2 = 1'b1;
    @(posedge clk); #1; start2 = 1'b0;
    ok2 = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk); #1;
      if (done2 === 1'b1) begin ok2 = 1'b1; break; end
    end
    checks++; if (!ok2 || {busy2, ovf2, res_cnt2} !== {1'b0, 1'b0, 6'd6}) begin errors++; $display("FAIL small_done: got seen=%b busy=%b ovf=%b cnt=%0d expected 1 0 0 6", ok2, busy2, ovf2, res_cnt2); end
    repeat (3) @(posedge clk); #1;
    checks++; if (hs2_n - b2 != 6 || done2_n - d2 != 1) begin errors++; $display("FAIL small_count: got %0d hs %0d dones expected 6 1", hs2_n - b2, done2_n - d2); end
    bad_ord = 0;
    for (int n = 0; n < 6; n++) if (hs2_row[b2+n] != n / 3 || hs2_col[b2+n] != n % 3) bad_ord++;
    checks++; if (bad_ord != 0) begin errors++; $display("FAIL small_order: got %0d bad expected 0", bad_ord); end
    checks++; if (hs2_data[b2] !== e0) begin errors++; $display("FAIL small_first_taps: got %h expected %h", hs2_data[b2], e0); end
    checks++; if (hs2_data[b2+5] !== e5) begin errors++; $display("FAIL small_last_taps: got %h expected %h", hs2_data[b2+5], e5); end
  endtask

  initial begin
    exp_first = {8'd18, 8'd17, 8'd16, 8'd10, 8'd9, 8'd8, 8'd2, 8'd1, 8'd0};
    exp_last  = {8'd63, 8'd62, 8'd61, 8'd55, 8'd54, 8'd53, 8'd47, 8'd46, 8'd45};
    exp_stall = {8'd37, 8'd36, 8'd35, 8'd29, 8'd28, 8'd27, 8'd21, 8'd20, 8'd19};
    test_reset();
    test_first_window();
    test_full_frame();
    test_backpressure();
    test_reset_mid_fetch();
    test_busy_start_stray();
    test_small_image();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
